// File: rtl/hi_lo_register_pkg.sv
// Shared funct codes and HI/LO controller state encoding, also used by the multiplier and ALU
// control.
package hi_lo_register_pkg;

  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMthi  = 6'b010001;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMtlo  = 6'b010011;
  localparam logic [5:0] FunctMultu = 6'b011001;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } hi_lo_state_e;

  // Rising edge of MULTU on the funct bus; a held MULTU starts only one product.
  function automatic logic multu_accept(input logic [5:0] funct, input logic [5:0] prev_funct);
    return (funct == FunctMultu) && (prev_funct != FunctMultu);
  endfunction

endpackage

// File: rtl/mul_latency_timer.sv
// Down-counter that times a fixed-latency functional unit: load, decrement, zero flag.
module mul_latency_timer #(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned LOAD_VALUE = 33
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CNT_W'(LOAD_VALUE);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/hi_lo_register.sv
// Architectural HI/LO for the iterative multiplier: times the product latency, captures the
// 64-bit result, serves MFHI/MFLO/MTHI/MTLO and flags busy while a product is pending.
module hi_lo_register
  import hi_lo_register_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 34,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  signal,
  input  logic [63:0] mulResult,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        busy
);

  localparam int unsigned LoadValue = MUL_LATENCY - 1;

  hi_lo_state_e state_q, state_d;
  logic [5:0]   prev_signal_q, prev_signal_d;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  lo_q, lo_d;
  logic [31:0]  data_out_q, data_out_d;
  logic         busy_q, busy_d;

  logic accept;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  assign accept = multu_accept(signal, prev_signal_q);

  mul_latency_timer #(
    .CNT_W      (CNT_W),
    .LOAD_VALUE (LoadValue)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .zero_o (timer_zero)
  );

  always_comb begin
    state_d       = state_q;
    prev_signal_d = signal;
    hi_d          = hi_q;
    lo_d          = lo_q;
    data_out_d    = data_out_q;
    busy_d        = busy_q;
    timer_load    = 1'b0;
    timer_dec     = 1'b0;

    case (state_q)
      StWait: begin
        // mulResult is only sampled here, so X on it elsewhere never reaches HI/LO.
        if (timer_zero) begin
          hi_d    = mulResult[63:32];
          lo_d    = mulResult[31:0];
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          timer_dec = 1'b1;
        end
        // A restart discards the in-flight product, same as the multiplier does.
        if (accept) begin
          timer_load = 1'b1;
          timer_dec  = 1'b0;
          busy_d     = 1'b1;
          state_d    = StWait;
        end
      end

      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          timer_load = 1'b1;
          busy_d     = 1'b1;
          state_d    = StWait;
        end else begin
          case (signal)
            FunctMthi: hi_d       = dataIn;
            FunctMtlo: lo_d       = dataIn;
            FunctMfhi: data_out_d = hi_q;
            FunctMflo: data_out_d = lo_q;
            default:   ;
          endcase
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      prev_signal_q <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      data_out_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_signal_q <= prev_signal_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      data_out_q    <= data_out_d;
      busy_q        <= busy_d;
    end
  end

  assign dataOut = data_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_hi_lo_register.sv
// Directed plus random bench for hi_lo_register against a cycle-count model of HI/LO.
module tb_hi_lo_register;

  localparam int unsigned Latency = 34;

  localparam logic [5:0] Mfhi  = 6'b010000;
  localparam logic [5:0] Mthi  = 6'b010001;
  localparam logic [5:0] Mflo  = 6'b010010;
  localparam logic [5:0] Mtlo  = 6'b010011;
  localparam logic [5:0] Multu = 6'b011001;
  localparam logic [5:0] Nop   = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  signal;
  logic [63:0] mulResult;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: a pending product is just "cycles left until capture".
  logic [31:0] m_hi, m_lo, m_dout;
  logic [5:0]  m_prev;
  bit          m_pend;
  int          m_left;

  hi_lo_register #(
    .MUL_LATENCY (34),
    .CNT_W       (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .signal    (signal),
    .mulResult (mulResult),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_dout = '0; m_prev = '0; m_pend = 0; m_left = 0;
  endtask

  task automatic model_edge(input logic [5:0] s, input logic [31:0] d, input logic [63:0] m);
    bit acc;
    bit idle;
    acc  = (s == Multu) && (m_prev != Multu);
    idle = !m_pend;
    if (m_pend && m_left == 1) begin
      m_hi = m[63:32];
      m_lo = m[31:0];
    end
    if (idle && !acc) begin
      if (s == Mthi) m_hi = d;
      if (s == Mtlo) m_lo = d;
      if (s == Mfhi) m_dout = m_hi;
      if (s == Mflo) m_dout = m_lo;
    end
    if (acc) begin
      m_pend = 1;
      m_left = Latency;
    end else if (m_pend) begin
      m_left--;
      if (m_left == 0) m_pend = 0;
    end
    m_prev = s;
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic [5:0] s, input logic [31:0] d, input logic [63:0] m);
    signal = s; dataIn = d; mulResult = m;
    @(posedge clk);
    model_edge(s, d, m);
    #1;
    check32("dout", dataOut, m_dout);
    check1("busy", busy, m_pend);
    @(negedge clk);
  endtask

  int          busy_cnt;
  logic [31:0] saved;
  logic [5:0]  rs;

  initial begin
    reset = 1'b1; signal = Nop; dataIn = '0; mulResult = '0;
    model_reset();
    #1;
    check1("rst_busy", busy, 1'b0);
    check32("rst_dout", dataOut, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // MTHI then MFHI in idle.
    step(Mthi, 32'hDEADBEEF, '0);
    step(Mfhi, '0, '0);
    check32("mfhi_after_mthi", dataOut, 32'hDEADBEEF);

    // Single MULTU pulse; MTLO during WAIT must not write lo.
    busy_cnt = 0;
    step(Multu, '0, 64'h00000002_FFFFFFFD);
    if (busy) busy_cnt++;
    step(Mtlo, 32'h55AA55AA, 64'h00000002_FFFFFFFD);
    check32("lo_mtlo_in_wait", dut.lo_q, m_lo);
    if (busy) busy_cnt++;
    for (int i = 0; i < 40; i++) begin
      step(Nop, '0, 64'h00000002_FFFFFFFD);
      if (busy) busy_cnt++;
    end
    check32("busy_width_single", busy_cnt, Latency);
    step(Mfhi, '0, '0);
    check32("mult_hi", dataOut, 32'h00000002);
    step(Mflo, '0, '0);
    check32("mult_lo", dataOut, 32'hFFFFFFFD);

    // MULTU held for 5 cycles: one accept, timed from the first edge.
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(Multu, '0, 64'h11111111_22222222);
      if (busy) busy_cnt++;
    end
    for (int i = 0; i < 40; i++) begin
      step(Nop, '0, 64'h11111111_22222222);
      if (busy) busy_cnt++;
    end
    check32("busy_width_held", busy_cnt, Latency);

    // Restart at cycle 20 of WAIT.
    busy_cnt = 0;
    step(Multu, '0, 64'hFFFFFFFF_FFFFFFFF);
    if (busy) busy_cnt++;
    for (int i = 1; i < 20; i++) begin
      step(Nop, '0, 64'hFFFFFFFF_FFFFFFFF);
      if (busy) busy_cnt++;
    end
    step(Multu, '0, 64'h0000000A_00000001);
    if (busy) busy_cnt++;
    for (int i = 0; i < 45; i++) begin
      step(Nop, '0, 64'h0000000A_00000001);
      if (busy) busy_cnt++;
    end
    check32("busy_width_restart", busy_cnt, 20 + Latency);
    step(Mfhi, '0, '0);
    check32("restart_hi", dataOut, 32'h0000000A);

    // MFLO on the capture edge is dropped, the re-presented one returns the new lo.
    step(Multu, '0, 64'h12345678_9ABCDEF0);
    for (int i = 1; i < Latency; i++) step(Nop, '0, 64'h12345678_9ABCDEF0);
    step(Mflo, '0, 64'h12345678_9ABCDEF0);
    check32("mflo_on_capture", dataOut, 32'h0000000A);
    step(Mflo, '0, '0);
    check32("mflo_after_capture", dataOut, 32'h9ABCDEF0);

    // Asynchronous reset at cycle 10 of WAIT aborts the product.
    step(Multu, '0, 64'hCAFEF00D_BAADF00D);
    for (int i = 1; i < 10; i++) step(Nop, '0, 64'hCAFEF00D_BAADF00D);
    reset = 1'b1;
    model_reset();
    #1;
    check1("async_rst_busy", busy, 1'b0);
    check32("async_rst_dout", dataOut, 32'h0);
    check32("async_rst_hi", dut.hi_q, 32'h0);
    check32("async_rst_lo", dut.lo_q, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) step(Nop, '0, 64'h77777777_88888888);
    step(Mfhi, '0, '0);
    check32("post_rst_hi", dataOut, 32'h0);
    step(Mflo, '0, '0);
    check32("post_rst_lo", dataOut, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 15))
        0, 1, 2:  rs = Mfhi;
        3, 4, 5:  rs = Mflo;
        6, 7:     rs = Mthi;
        8, 9:     rs = Mtlo;
        10:       rs = Multu;
        11:       rs = 6'($urandom);
        default:  rs = Nop;
      endcase
      step(rs, $urandom, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
